pyc_mem_arb: RTL and testbench
==============================

# pyc_mem_arb

Round-robin arbiter that shares one `pyc_sync_mem` (1R1W, registered read) among `NREQ` requesters. Read and write ports are arbitrated independently. Each granted read request is tagged so that the next-cycle memory read data returns to the requester that issued it. The block sits between core-side load/store clients and a single memory instance, and drives that instance's ports directly.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `ADDR_WIDTH`, 64: entry address width, matching the memory.
- `DATA_WIDTH`, 64: word width, a multiple of 8.
- `STRB_WIDTH`, `DATA_WIDTH/8`: derived, not overridable.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_req_valid`  in  NREQ  per-requester read request.
- `rd_req_addr`  in  NREQ*ADDR_WIDTH  packed read addresses; requester i uses slice i.
- `rd_req_ready`  out  NREQ  one-hot read grant (combinational).
- `rd_rsp_valid`  out  NREQ  one-hot, registered read response strobe.
- `rd_rsp_data`  out  DATA_WIDTH  read data shared by all requesters, qualified by `rd_rsp_valid`.
- `wr_req_valid`  in  NREQ  per-requester write request.
- `wr_req_addr`  in  NREQ*ADDR_WIDTH  packed write addresses.
- `wr_req_data`  in  NREQ*DATA_WIDTH  packed write data.
- `wr_req_strb`  in  NREQ*STRB_WIDTH  packed byte enables.
- `wr_req_ready`  out  NREQ  one-hot write grant (combinational).
- `mem_ren`  out  1  memory read enable.
- `mem_raddr`  out  ADDR_WIDTH  memory read address.
- `mem_rdata`  in  DATA_WIDTH  memory registered read data.
- `mem_wvalid`  out  1  memory write valid.
- `mem_waddr`  out  ADDR_WIDTH  memory write address.
- `mem_wdata`  out  DATA_WIDTH  memory write data.
- `mem_wstrb`  out  STRB_WIDTH  memory byte enables.

## Operation
- **Read arbiter.**
  - Keeps a registered pointer `rd_ptr` (log2 NREQ bits).
  - Each cycle it grants the first valid requester found searching `rd_ptr`, `rd_ptr+1`, … modulo NREQ.
  - `rd_req_ready[g]` is 1 only for the granted index g; all other ready bits are 0.
  - With no valid requester, `rd_req_ready` is 0.
- **Write arbiter.** Identical logic with its own pointer `wr_ptr`. It is fully independent of the read arbiter.
- **Pointer update.** On a grant to g, the pointer becomes (g+1) mod NREQ at the next edge. With no grant, the pointer holds.
- **Memory read drive.**
  - `mem_ren` = any read grant.
  - `mem_raddr` = address slice of g.
  - With no grant: `mem_raddr` = 0 and `mem_ren` = 0.
- **Memory write drive.**
  - `mem_wvalid` = any write grant.
  - `mem_waddr`, `mem_wdata`, `mem_wstrb` = slices of the granted writer.
  - With no grant, all three are 0.
- **Response tag.** The registered one-hot `rsp_sel` is loaded with the read grant vector every cycle, or with 0 when there is no grant.
  - `rd_rsp_valid` = `rsp_sel`.
  - `rd_rsp_data` = `mem_rdata`.
- **No response backpressure.** A requester must accept the response in the cycle it is presented.
- **Same-address read and write in one cycle** (from any requesters): the response carries the newly written bytes. This is write-first, provided by the memory.
- **Out-of-range addresses** are passed through unchanged. Reads return 0 and writes are dropped, per memory behaviour.
- **Requester rules.** A requester may deassert valid or change its address/data before a grant. The arbiter holds no request state beyond the pointers and `rsp_sel`.

## Timing
- Request-to-grant: 0 cycles (combinational ready).
- Read latency: grant at edge N produces `rd_rsp_valid`/`rd_rsp_data` during cycle N+1.
- Throughput: one read and one write per cycle, sustained.
- Write: committed at the grant edge and visible to a read granted in the same cycle.
- **Reset values:** `rd_ptr` = 0, `wr_ptr` = 0, `rsp_sel` = 0, so `rd_rsp_valid` = 0.
  - Grant outputs follow inputs combinationally during reset but must be ignored.
  - `mem_ren` and `mem_wvalid` are forced to 0 while `rst` = 1.
- **Reset mid-operation:** a response pending from a grant in the cycle before `rst` is dropped; `rd_rsp_valid` = 0 in the cycle after reset.
- **Wrap-around:**
  - With `rd_ptr` = NREQ-1 and only requester 0 valid, requester 0 is granted and `rd_ptr` becomes 1.
  - A grant to NREQ-1 sets the pointer to 0.

## Test plan
- **Single read:** mem[5] = 0xAA, req1 reads addr 5 at cycle 3 → `rd_req_ready` = 0b0010 at cycle 3; `rd_rsp_valid` = 0b0010 with `rd_rsp_data` = 0xAA at cycle 4.
- **Fairness:** all 4 requesters hold reads continuously from reset → grants 0,1,2,3,0,1… for 8 cycles; each response is tagged to the matching requester one cycle later.
- **Concurrent read and write:** req2 writes 0x1122 to addr 9 with strb = 0xFF while req0 reads addr 9 in the same cycle → req0 gets 0x1122 the next cycle.
- **Byte strobe:** mem[4] = 0xFFFF_FFFF_FFFF_FFFF, write 0 with strb = 0x01, then read addr 4 → 0xFFFF_FFFF_FFFF_FF00.
- **Wrap and skip:** `rd_ptr` = 3, only req0 and req2 valid → req0 granted, then req2, then req0.
- **Reset mid-flight:** grant req3 read at cycle N, `rst` = 1 at cycle N+1 → `rd_rsp_valid` = 0 at N+1 and N+2; after release, req1 alone is granted first and `rd_ptr` restarts from 0.

Source files
------------

// File: rtl/pyc_mem_arb.sv
// pyc_mem_arb
// Shares one 1R1W registered-read memory among NREQ requesters. Reads and
// writes each have their own round-robin arbiter. A one-hot tag follows every
// granted read by one cycle so the returning data reaches the right requester.
module pyc_mem_arb #(
   parameter int NREQ       = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NREQ-1:0]                     rd_req_valid,
   input  logic [NREQ*ADDR_WIDTH-1:0]          rd_req_addr,
   output logic [NREQ-1:0]                     rd_req_ready,
   output logic [NREQ-1:0]                     rd_rsp_valid,
   output logic [DATA_WIDTH-1:0]               rd_rsp_data,
   input  logic [NREQ-1:0]                     wr_req_valid,
   input  logic [NREQ*ADDR_WIDTH-1:0]          wr_req_addr,
   input  logic [NREQ*DATA_WIDTH-1:0]          wr_req_data,
   input  logic [NREQ*(DATA_WIDTH/8)-1:0]      wr_req_strb,
   output logic [NREQ-1:0]                     wr_req_ready,
   output logic                                mem_ren,
   output logic [ADDR_WIDTH-1:0]               mem_raddr,
   input  logic [DATA_WIDTH-1:0]               mem_rdata,
   output logic                                mem_wvalid,
   output logic [ADDR_WIDTH-1:0]               mem_waddr,
   output logic [DATA_WIDTH-1:0]               mem_wdata,
   output logic [(DATA_WIDTH/8)-1:0]           mem_wstrb
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int PTR_W      = $clog2(NREQ);
   localparam int POS_W      = PTR_W + 1;

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [NREQ-1:0]  rsp_sel;

   logic             rd_hit;
   logic             wr_hit;
   logic [PTR_W-1:0] rd_idx;
   logic [PTR_W-1:0] wr_idx;
   logic [NREQ-1:0]  rd_grant;
   logic [NREQ-1:0]  wr_grant;

   // Searches ptr, ptr+1, ... (mod NREQ) and returns {found, index} of the
   // first valid requester. The position is kept one bit wider so the wrap
   // works for any NREQ, not only powers of two.
   function automatic logic [POS_W-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [PTR_W-1:0] ptr);
      logic [POS_W-1:0] pos;
      logic [POS_W-1:0] pick;
      pick = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = {1'b0, ptr} + POS_W'(k);
         if (pos >= POS_W'(NREQ)) begin
            pos = pos - POS_W'(NREQ);
         end
         if (!pick[PTR_W] && valid[pos[PTR_W-1:0]]) begin
            pick = {1'b1, pos[PTR_W-1:0]};
         end
      end
      return pick;
   endfunction

   // Index following a granted requester, wrapping NREQ-1 back to 0.
   function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] g);
      logic [PTR_W-1:0] nxt;
      if (g == PTR_W'(NREQ - 1)) begin
         nxt = '0;
      end else begin
         nxt = g + 1'b1;
      end
      return nxt;
   endfunction

   // Both arbiters pick a winner from their own pointer and form a one-hot grant.
   always_comb begin
      {rd_hit, rd_idx} = rr_pick(rd_req_valid, rd_ptr);
      {wr_hit, wr_idx} = rr_pick(wr_req_valid, wr_ptr);
      rd_grant = rd_hit ? (NREQ'(1) << rd_idx) : '0;
      wr_grant = wr_hit ? (NREQ'(1) << wr_idx) : '0;
   end

   assign rd_req_ready = rd_grant;
   assign wr_req_ready = wr_grant;

   // Read port mux: the one-hot grant selects the winner's address, zero when idle.
   always_comb begin
      mem_raddr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (rd_grant[i]) begin
            mem_raddr = rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   // Write port mux: address, data and strobes of the winning writer, zero when idle.
   always_comb begin
      mem_waddr = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (wr_grant[i]) begin
            mem_waddr = wr_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata = wr_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            mem_wstrb = wr_req_strb[i*STRB_WIDTH +: STRB_WIDTH];
         end
      end
   end

   // Memory enables are suppressed during reset so no access leaks out while
   // the grants still follow the inputs.
   assign mem_ren    = rd_hit & ~rst;
   assign mem_wvalid = wr_hit & ~rst;

   // Pointers advance past the winner on a grant and hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (rd_hit) begin
            rd_ptr <= ptr_after(rd_idx);
         end
         if (wr_hit) begin
            wr_ptr <= ptr_after(wr_idx);
         end
      end
   end

   // Response tag tracks the read grant so it lines up with the memory's
   // one-cycle registered read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_sel <= '0;
      end else begin
         rsp_sel <= rd_grant;
      end
   end

   // A response due in a reset cycle is dropped rather than delivered.
   assign rd_rsp_valid = rst ? '0 : rsp_sel;
   assign rd_rsp_data  = mem_rdata;

endmodule

// File: tb/tb_pyc_mem_arb.sv
// tb_pyc_mem_arb
// Random and directed traffic against pyc_mem_arb with a behavioural memory
// attached to its memory ports. A reference model predicts grants, memory
// port values and read responses; responses are queued and checked by a
// separate monitor when they come due.
module tb_pyc_mem_arb;

   localparam int NREQ  = 4;
   localparam int AW    = 64;
   localparam int DW    = 64;
   localparam int SW    = DW / 8;
   localparam int DEPTH = 32;

   typedef struct {
      int              due;
      logic [NREQ-1:0] tag;
      logic [DW-1:0]   data;
   } rsp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      rd_req_valid = '0;
   logic [NREQ*AW-1:0]   rd_req_addr = '0;
   logic [NREQ-1:0]      rd_req_ready;
   logic [NREQ-1:0]      rd_rsp_valid;
   logic [DW-1:0]        rd_rsp_data;
   logic [NREQ-1:0]      wr_req_valid = '0;
   logic [NREQ*AW-1:0]   wr_req_addr = '0;
   logic [NREQ*DW-1:0]   wr_req_data = '0;
   logic [NREQ*SW-1:0]   wr_req_strb = '0;
   logic [NREQ-1:0]      wr_req_ready;
   logic                 mem_ren;
   logic [AW-1:0]        mem_raddr;
   logic [DW-1:0]        mem_rdata;
   logic                 mem_wvalid;
   logic [AW-1:0]        mem_waddr;
   logic [DW-1:0]        mem_wdata;
   logic [SW-1:0]        mem_wstrb;

   int n_cmp = 0;
   int n_bad = 0;
   int cycle = 0;
   bit done  = 1'b0;

   int            rd_ptr_m = 0;
   int            wr_ptr_m = 0;
   logic [DW-1:0] ref_mem  [DEPTH];
   logic [DW-1:0] phys_mem [DEPTH];
   bit            phys_loaded = 1'b0;
   rsp_t          q [$];

   logic [NREQ*AW-1:0] ra;
   logic [NREQ*AW-1:0] wa;
   logic [NREQ*DW-1:0] wd;
   logic [NREQ*SW-1:0] ws;

   pyc_mem_arb #(
      .NREQ       (NREQ),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rd_req_valid (rd_req_valid),
      .rd_req_addr  (rd_req_addr),
      .rd_req_ready (rd_req_ready),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_data  (rd_rsp_data),
      .wr_req_valid (wr_req_valid),
      .wr_req_addr  (wr_req_addr),
      .wr_req_data  (wr_req_data),
      .wr_req_strb  (wr_req_strb),
      .wr_req_ready (wr_req_ready),
      .mem_ren      (mem_ren),
      .mem_raddr    (mem_raddr),
      .mem_rdata    (mem_rdata),
      .mem_wvalid   (mem_wvalid),
      .mem_waddr    (mem_waddr),
      .mem_wdata    (mem_wdata),
      .mem_wstrb    (mem_wstrb)
   );

   // Free-running clock and a cycle counter shared by driver and monitor.
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Initial memory image; entries 4 and 5 carry the directed-test values.
   function automatic logic [DW-1:0] init_val(input int i);
      logic [DW-1:0] v;
      v = 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
      if (i == 4) v = '1;
      if (i == 5) v = 64'hAA;
      return v;
   endfunction

   // Applies byte enables: bytes with their strobe set take the new value.
   function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old,
                                                input logic [DW-1:0] d,
                                                input logic [SW-1:0] s);
      logic [DW-1:0] m;
      logic [SW-1:0] sh;
      m = '0;
      for (int b = 0; b < SW; b++) begin
         sh = s >> b;
         if (sh[0]) m = m | (DW'(8'hFF) << (8 * b));
      end
      return (old & ~m) | (d & m);
   endfunction

   // Round-robin rule: first valid index scanning from ptr upward, modulo NREQ.
   function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
      logic [NREQ-1:0] sh;
      for (int k = 0; k < NREQ; k++) begin
         sh = v >> ((ptr + k) % NREQ);
         if (sh[0]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   // Stand-in for the shared memory: write-first, registered read, out-of-range
   // reads return 0 and out-of-range writes are dropped.
   always @(posedge clk) begin
      if (!phys_loaded) begin
         for (int i = 0; i < DEPTH; i++) phys_mem[i] = init_val(i);
         phys_loaded = 1'b1;
      end
      if (mem_wvalid && mem_waddr < 64'(DEPTH))
         phys_mem[mem_waddr[4:0]] = byte_merge(phys_mem[mem_waddr[4:0]], mem_wdata, mem_wstrb);
      if (mem_ren)
         mem_rdata <= (mem_raddr < 64'(DEPTH)) ? phys_mem[mem_raddr[4:0]] : '0;
   end

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
      end
   endtask

   // Drives one cycle of requests, checks the combinational grant and memory
   // ports against the model, and queues the read response it predicts.
   task automatic apply_stimulus(input logic r,
                                 input logic [NREQ-1:0] rv, input logic [NREQ*AW-1:0] rav,
                                 input logic [NREQ-1:0] wv, input logic [NREQ*AW-1:0] wav,
                                 input logic [NREQ*DW-1:0] wdv, input logic [NREQ*SW-1:0] wsv);
      int              gr;
      int              gw;
      logic [NREQ-1:0] exp_rg;
      logic [NREQ-1:0] exp_wg;
      logic [AW-1:0]   a;
      logic [DW-1:0]   d;
      @(posedge clk);
      #1;
      rst          = r;
      rd_req_valid = rv;
      rd_req_addr  = rav;
      wr_req_valid = wv;
      wr_req_addr  = wav;
      wr_req_data  = wdv;
      wr_req_strb  = wsv;
      #3;
      if (r) begin
         check_output("mem_ren_in_reset", DW'(mem_ren), '0);
         check_output("mem_wvalid_in_reset", DW'(mem_wvalid), '0);
         if (q.size() > 0 && q[q.size()-1].due == cycle) q.delete(q.size() - 1);
         rd_ptr_m = 0;
         wr_ptr_m = 0;
      end else begin
         gr = ref_pick(rv, rd_ptr_m);
         gw = ref_pick(wv, wr_ptr_m);
         exp_rg = (gr >= 0) ? (NREQ'(1) << gr) : '0;
         exp_wg = (gw >= 0) ? (NREQ'(1) << gw) : '0;
         check_output("rd_req_ready", DW'(rd_req_ready), DW'(exp_rg));
         check_output("wr_req_ready", DW'(wr_req_ready), DW'(exp_wg));
         check_output("mem_ren", DW'(mem_ren), DW'(gr >= 0));
         check_output("mem_wvalid", DW'(mem_wvalid), DW'(gw >= 0));
         a = '0;
         if (gr >= 0) a = rav[gr*AW +: AW];
         check_output("mem_raddr", mem_raddr, a);
         if (gw >= 0) begin
            check_output("mem_waddr", mem_waddr, wav[gw*AW +: AW]);
            check_output("mem_wdata", mem_wdata, wdv[gw*DW +: DW]);
            check_output("mem_wstrb", DW'(mem_wstrb), DW'(wsv[gw*SW +: SW]));
            a = wav[gw*AW +: AW];
            if (a < 64'(DEPTH))
               ref_mem[a[4:0]] = byte_merge(ref_mem[a[4:0]], wdv[gw*DW +: DW], wsv[gw*SW +: SW]);
            wr_ptr_m = (gw + 1) % NREQ;
         end else begin
            check_output("mem_wport_idle", mem_waddr | mem_wdata | DW'(mem_wstrb), '0);
         end
         if (gr >= 0) begin
            a = rav[gr*AW +: AW];
            d = (a < 64'(DEPTH)) ? ref_mem[a[4:0]] : '0;
            q.push_back('{due: cycle + 1, tag: exp_rg, data: d});
            rd_ptr_m = (gr + 1) % NREQ;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, '0, '0, '0, '0, '0);
   endtask

   // Monitor: every cycle the response strobe must equal the tag due now
   // (or zero), and the data must match whenever a response is presented.
   always @(negedge clk) begin
      logic [NREQ-1:0] exp_v;
      logic [DW-1:0]   exp_d;
      if (!done) begin
         exp_v = '0;
         exp_d = '0;
         if (q.size() > 0 && q[0].due == cycle) begin
            exp_v = q[0].tag;
            exp_d = q[0].data;
            q.delete(0);
         end
         check_output("rd_rsp_valid", DW'(rd_rsp_valid), DW'(exp_v));
         if (exp_v != '0) check_output("rd_rsp_data", rd_rsp_data, exp_d);
      end
   end

   // Directed scenarios first, then a long randomized run with occasional resets.
   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
      ra = '0; wa = '0; wd = '0; ws = '0;

      // Reset with every requester asking: memory enables must stay low.
      repeat (3) apply_stimulus(1'b1, '1, ra, '1, wa, wd, ws);

      // Single read: requester 1 reads address 5.
      idle(1);
      ra = '0; ra[1*AW +: AW] = 64'd5;
      apply_stimulus(1'b0, 4'b0010, ra, '0, wa, wd, ws);
      idle(1);

      // Fairness: all readers held valid straight out of reset.
      apply_stimulus(1'b1, '0, '0, '0, '0, '0, '0);
      for (int c = 0; c < 8; c++) begin
         for (int r = 0; r < NREQ; r++) ra[r*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
         apply_stimulus(1'b0, '1, ra, '0, wa, wd, ws);
      end

      // Same-address read and write in one cycle returns the new data.
      ra = '0; ra[0 +: AW] = 64'd9;
      wa = '0; wa[2*AW +: AW] = 64'd9;
      wd = '0; wd[2*DW +: DW] = 64'h1122;
      ws = '0; ws[2*SW +: SW] = '1;
      apply_stimulus(1'b0, 4'b0001, ra, 4'b0100, wa, wd, ws);
      idle(1);

      // Byte strobe: clear only byte 0 of an all-ones word, then read it back.
      wa = '0; wa[0 +: AW] = 64'd4;
      wd = '0;
      ws = '0; ws[0 +: SW] = 8'h01;
      apply_stimulus(1'b0, '0, '0, 4'b0001, wa, wd, ws);
      ra = '0; ra[3*AW +: AW] = 64'd4;
      apply_stimulus(1'b0, 4'b1000, ra, '0, '0, '0, '0);
      idle(1);

      // Wrap and skip: move the read pointer to 3, then only 0 and 2 request.
      apply_stimulus(1'b1, '0, '0, '0, '0, '0, '0);
      ra = '0; ra[2*AW +: AW] = 64'd2;
      apply_stimulus(1'b0, 4'b0100, ra, '0, '0, '0, '0);
      ra[0 +: AW] = 64'd1;
      repeat (3) apply_stimulus(1'b0, 4'b0101, ra, '0, '0, '0, '0);

      // Reset mid-flight: the pending response for requester 3 is dropped.
      ra = '0; ra[3*AW +: AW] = 64'd7;
      apply_stimulus(1'b0, 4'b1000, ra, '0, '0, '0, '0);
      apply_stimulus(1'b1, '1, ra, '1, '0, '0, '0);
      ra[1*AW +: AW] = 64'd6;
      apply_stimulus(1'b0, 4'b0010, ra, '0, '0, '0, '0);
      repeat (4) apply_stimulus(1'b0, '1, ra, '0, '0, '0, '0);

      // Out-of-range: write and read a far address, then confirm no aliasing.
      ra = '0; ra[0 +: AW] = 64'hFFFF_0000_0000_0005;
      wa = '0; wa[1*AW +: AW] = 64'hFFFF_0000_0000_0005;
      wd = '0; wd[1*DW +: DW] = 64'hDEAD_BEEF_0000_1234;
      ws = '0; ws[1*SW +: SW] = '1;
      apply_stimulus(1'b0, 4'b0001, ra, 4'b0010, wa, wd, ws);
      ra[0 +: AW] = 64'd5;
      apply_stimulus(1'b0, 4'b0001, ra, '0, '0, '0, '0);
      ra[0 +: AW] = 64'(DEPTH + 2);
      apply_stimulus(1'b0, 4'b0001, ra, '0, '0, '0, '0);

      // Randomized traffic on a small address range so collisions are frequent.
      for (int c = 0; c < 600; c++) begin
         for (int r = 0; r < NREQ; r++) begin
            ra[r*AW +: AW] = AW'($urandom_range(0, DEPTH + 3));
            wa[r*AW +: AW] = AW'($urandom_range(0, DEPTH + 3));
            wd[r*DW +: DW] = {$urandom, $urandom};
            ws[r*SW +: SW] = SW'($urandom);
         end
         apply_stimulus(($urandom_range(0, 63) == 0), NREQ'($urandom), ra, NREQ'($urandom), wa, wd, ws);
      end

      idle(3);
      @(negedge clk);
      #1;
      done = 1'b1;
      check_output("rsp_queue_drained", DW'(q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
